perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 147 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of event counters with START/STOP/CLEAR/SNAPSHOT
// control, atomic snapshot registers and a one-cycle-latency snapshot read port.
module perf_counter_bank #(
   parameter  int unsigned NUM_CH = 8,
   parameter  int unsigned CNT_W  = 48,
   parameter  int unsigned INC_W  = 2,
   localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH*INC_W-1:0]   event_inc,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic                      cmd_valid,
   input  logic [1:0]                cmd_op,
   output logic                      cmd_ready,
   input  logic [SEL_W-1:0]          rd_sel,
   output logic [CNT_W-1:0]          rd_data,
   output logic [NUM_CH-1:0]         ovf,
   output logic                      running,
   output logic                      snap_valid
);

   localparam int unsigned SUM_W = CNT_W + 1;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_SNAP  = 2'b11;

   typedef enum logic [1:0] {
      ST_STOPPED  = 2'b00,
      ST_RUNNING  = 2'b01,
      ST_CLEARING = 2'b10
   } state_t;

   state_t           state;
   logic             ret_run;
   logic             cmd_acc;
   logic             clr_acc;
   logic             snap_acc;
   logic             count_en;
   logic [CNT_W-1:0] cnt  [NUM_CH];
   logic [CNT_W-1:0] snap [NUM_CH];
   logic [SUM_W-1:0] sum  [NUM_CH];

   // Command handshake decode; cmd_ready is already low in CLEARING
   always_comb begin
      cmd_acc  = cmd_valid & cmd_ready;
      clr_acc  = cmd_acc & (cmd_op == OP_CLEAR);
      snap_acc = cmd_acc & (cmd_op == OP_SNAP);
      count_en = (state == ST_RUNNING) & ~clr_acc;
   end

   // Per-channel next count with carry bit for wrap detection
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = {1'b0, cnt[i]} + SUM_W'(event_inc[i*INC_W +: INC_W]);
      end
   end

   // Control FSM with registered cmd_ready and running; CLEARING remembers where to return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_STOPPED;
         ret_run   <= 1'b0;
         cmd_ready <= 1'b1;
         running   <= 1'b0;
      end else begin
         case (state)
            ST_STOPPED, ST_RUNNING: begin
               if (cmd_acc) begin
                  case (cmd_op)
                     OP_START: begin
                        state   <= ST_RUNNING;
                        running <= 1'b1;
                     end
                     OP_STOP: begin
                        state   <= ST_STOPPED;
                        running <= 1'b0;
                     end
                     OP_CLEAR: begin
                        state     <= ST_CLEARING;
                        ret_run   <= (state == ST_RUNNING);
                        cmd_ready <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_CLEARING: begin
               state     <= ret_run ? ST_RUNNING : ST_STOPPED;
               cmd_ready <= 1'b1;
               running   <= ret_run;
            end
            default: begin
               state     <= ST_STOPPED;
               cmd_ready <= 1'b1;
               running   <= 1'b0;
            end
         endcase
      end
   end

   // Event counters with sticky wrap flags; zeroed on the edge that accepts CLEAR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         ovf <= '0;
      end else if (clr_acc) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         ovf <= '0;
      end else if (count_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_enable[i]) begin
               cnt[i] <= sum[i][CNT_W-1:0];
               if (sum[i][CNT_W]) ovf[i] <= 1'b1;
            end
         end
      end
   end

   // Snapshot registers capture pre-increment counts atomically
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
         snap_valid <= 1'b0;
      end else if (clr_acc) begin
         for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
         snap_valid <= 1'b0;
      end else if (snap_acc) begin
         for (int i = 0; i < NUM_CH; i++) snap[i] <= cnt[i];
         snap_valid <= 1'b1;
      end
   end

   // Registered snapshot read; out-of-range selects read as zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (32'(rd_sel) < NUM_CH) begin
         rd_data <= snap[rd_sel];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (6 channels, 8-bit counters).
module tb_perf_counter_bank;

   localparam int unsigned NUM_CH = 6;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned INC_W  = 2;
   localparam int unsigned SEL_W  = $clog2(NUM_CH);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_SNAP  = 2'b11;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_CH*INC_W-1:0] event_inc;
   logic [NUM_CH-1:0]       ch_enable;
   logic                    cmd_valid;
   logic [1:0]              cmd_op;
   logic                    cmd_ready;
   logic [SEL_W-1:0]        rd_sel;
   logic [CNT_W-1:0]        rd_data;
   logic [NUM_CH-1:0]       ovf;
   logic                    running;
   logic                    snap_valid;

   int checks   = 0;
   int failures = 0;

   perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .event_inc  (event_inc),
      .ch_enable  (ch_enable),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_ready  (cmd_ready),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .ovf        (ovf),
      .running    (running),
      .snap_valid (snap_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic read_ch(input int ch);
      rd_sel = SEL_W'(ch);
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      event_inc = '0;
      ch_enable = '1;
      cmd_valid = 1'b0;
      cmd_op    = OP_START;
      rd_sel    = '0;
      repeat (2) tick();
      reset = 1'b0;

      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_running", 64'(running), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_snap_valid", 64'(snap_valid), 64'd0);

      // Scenario 1: ch0 +1, ch1 +3 for 10 cycles
      cmd(OP_START);
      check("s1_running", 64'(running), 64'd1);
      event_inc = {8'h00, 2'd3, 2'd1};
      repeat (10) tick();
      event_inc = '0;
      cmd(OP_STOP);
      check("s1_stopped", 64'(running), 64'd0);
      cmd(OP_SNAP);
      check("s1_snap_valid", 64'(snap_valid), 64'd1);
      read_ch(0);
      check("s1_ch0", 64'(rd_data), 64'd10);
      read_ch(1);
      check("s1_ch1", 64'(rd_data), 64'd30);
      check("s1_ovf", 64'(ovf), 64'd0);

      // Scenario 2: ch2 wraps after 257 single increments
      cmd(OP_CLEAR);
      check("s2_clr_ready", 64'(cmd_ready), 64'd0);
      check("s2_clr_snapv", 64'(snap_valid), 64'd0);
      tick();
      check("s2_ready_back", 64'(cmd_ready), 64'd1);
      cmd(OP_START);
      event_inc = {4'h0, 2'd1, 4'h0};
      repeat (255) tick();
      check("s2_no_ovf_255", 64'(ovf), 64'd0);
      repeat (2) tick();
      event_inc = '0;
      cmd(OP_STOP);
      cmd(OP_SNAP);
      read_ch(2);
      check("s2_wrap_val", 64'(rd_data), 64'd1);
      check("s2_ovf", 64'(ovf), 64'b000100);
      cmd(OP_CLEAR);
      check("s2_ovf_cleared", 64'(ovf), 64'd0);
      tick();
      check("s2_back_stopped", 64'(running), 64'd0);
      cmd(OP_SNAP);
      read_ch(2);
      check("s2_cnt_cleared", 64'(rd_data), 64'd0);

      // Scenario 3: CLEAR while running, all channels +1
      event_inc = {6{2'd1}};
      cmd(OP_START);
      repeat (3) tick();
      cmd(OP_CLEAR);
      check("s3_ready_low", 64'(cmd_ready), 64'd0);
      check("s3_running_hold", 64'(running), 64'd1);
      tick();
      check("s3_ready_high", 64'(cmd_ready), 64'd1);
      check("s3_running_after", 64'(running), 64'd1);
      rd_sel = SEL_W'(5);
      cmd(OP_SNAP);
      cmd(OP_SNAP);
      check("s3_cnt_zero", 64'(rd_data), 64'd0);
      tick();
      check("s3_cnt_resume", 64'(rd_data), 64'd1);

      // Scenario 4: snapshot of ch3 at 100 with +2 on the same edge, then 5 cycles later
      event_inc = '0;
      cmd(OP_STOP);
      cmd(OP_CLEAR);
      tick();
      cmd(OP_START);
      event_inc = {4'h0, 2'd2, 6'h00};
      repeat (50) tick();
      cmd(OP_SNAP);
      read_ch(3);
      check("s4_snap_first", 64'(rd_data), 64'd100);
      repeat (3) tick();
      cmd(OP_SNAP);
      tick();
      check("s4_snap_second", 64'(rd_data), 64'd110);

      // Scenario 5: ch4 disabled with +3 for 20 cycles
      event_inc = '0;
      cmd(OP_STOP);
      cmd(OP_CLEAR);
      tick();
      ch_enable = 6'b101111;
      event_inc = {6{2'd3}};
      cmd(OP_START);
      repeat (20) tick();
      event_inc = '0;
      cmd(OP_STOP);
      cmd(OP_SNAP);
      read_ch(4);
      check("s5_ch4_disabled", 64'(rd_data), 64'd0);
      read_ch(0);
      check("s5_ch0_counts", 64'(rd_data), 64'd60);
      read_ch(5);
      check("s5_ch5_counts", 64'(rd_data), 64'd60);
      ch_enable = '1;

      // Scenario 6: asynchronous reset between edges while counting
      cmd(OP_CLEAR);
      tick();
      event_inc = {6{2'd1}};
      cmd(OP_START);
      repeat (5) tick();
      cmd(OP_SNAP);
      read_ch(0);
      check("s6_pre_reset", 64'(rd_data), 64'd5);
      #2;
      reset = 1'b1;
      #1;
      check("s6_rd_data", 64'(rd_data), 64'd0);
      check("s6_cmd_ready", 64'(cmd_ready), 64'd1);
      check("s6_running", 64'(running), 64'd0);
      check("s6_snap_valid", 64'(snap_valid), 64'd0);
      check("s6_ovf", 64'(ovf), 64'd0);
      event_inc = '0;
      repeat (2) tick();
      reset = 1'b0;
      rd_sel = SEL_W'(NUM_CH);
      tick();
      check("s6_sel_oob", 64'(rd_data), 64'd0);
      cmd(OP_START);
      check("s6_start_after", 64'(running), 64'd1);
      cmd(OP_SNAP);
      read_ch(0);
      check("s6_cnt_discarded", 64'(rd_data), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
